// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter.
//   - region encodings carried in the requester address bits [7:6]
//   - arbiter FSM state type
//   - peripheral bus widths
package periph_bus_pkg;

    localparam int BUS_ADDR_W = 6;
    localparam int BUS_DATA_W = 8;

    localparam logic [1:0] REG_GPIOS  = 2'b00;
    localparam logic [1:0] REG_SERIAL = 2'b01;
    localparam logic [1:0] REG_TIMERS = 2'b10;
    localparam logic [1:0] REG_NONE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } bus_state_e;

    // Region field of a requester address.
    function automatic logic [1:0] addr_region(input logic [7:0] addr);
        return addr[7:6];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin grant selection (purely combinational).
//   req_i        : request levels, bit n = port n
//   last_grant_i : port granted most recently (register lives in the parent)
//   grant_o      : winning port index, meaningful only when valid_o is high
//   valid_o      : at least one port is requesting
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        // On a tie the port that did not win last time goes next;
        // a lone requester always wins.
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the 8-bit peripheral bus between the CPU (port 0) and a secondary
// host (port 1). Round-robin arbitration, region decode into per-peripheral
// write enables, registered read-data mux and a one-cycle ack per access.
//
// Ports:
//   wb_clk_i, rst                 clock, asynchronous active-high reset
//   m<n>_req/we/addr/wdata        requester n: level request held until ack,
//                                 write flag, {region[1:0], offset[5:0]}, data
//   m<n>_ack, m<n>_rdata          one-cycle completion pulse, read data (held)
//   bus_addr, bus_data_out        offset / write data of the granted access
//   bus_cyc                       one-cycle access strobe (not for region 11)
//   bus_we_gpios/serial_ports/timers  region-qualified write enables
//   bus_in_gpios/serial_ports/timers  peripheral read data
//   bus_owner                     index of the current or last grant
//
// Handshake: a requester raises req and holds it; the access is committed when
// granted in IDLE and always completes with exactly one ack pulse, even if req
// drops meanwhile. Every output comes straight from a register.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int         WAIT_CYCLES   = 1,     // legal 1..7
    parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic                  wb_clk_i,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [7:0]            m0_addr,
    input  logic [7:0]            m1_addr,
    input  logic [7:0]            m0_wdata,
    input  logic [7:0]            m1_wdata,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic [7:0]            m0_rdata,
    output logic [7:0]            m1_rdata,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic [BUS_DATA_W-1:0] bus_data_out,
    output logic                  bus_cyc,
    output logic                  bus_we_gpios,
    output logic                  bus_we_serial_ports,
    output logic                  bus_we_timers,
    input  logic [7:0]            bus_in_gpios,
    input  logic [7:0]            bus_in_serial_ports,
    input  logic [7:0]            bus_in_timers,
    output logic                  bus_owner
);

    // Terminal WAIT count: WAIT holds WAIT_CYCLES-1 cycles, counted 0..N-2.
    localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES > 1) ? 3'(WAIT_CYCLES - 2) : 3'd0;

    bus_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [BUS_ADDR_W-1:0] addr_q, addr_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0] region_q, region_d;
    logic       we_q, we_d;
    logic [2:0] cnt_q, cnt_d;
    logic       cyc_q, cyc_d;
    logic       we_g_q, we_g_d, we_s_q, we_s_d, we_t_q, we_t_d;
    logic       ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic       grant, valid;
    logic [7:0] win_addr, win_wdata;
    logic       win_we;
    logic [1:0] win_region;
    logic [7:0] sampled;
    logic       to_ack;

    rr_arbiter2 u_rr (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .valid_o      (valid)
    );

    assign win_addr   = grant ? m1_addr  : m0_addr;
    assign win_wdata  = grant ? m1_wdata : m0_wdata;
    assign win_we     = grant ? m1_we    : m0_we;
    assign win_region = addr_region(win_addr);

    // Read-data source for the latched region.
    always_comb begin
        unique case (region_q)
            REG_GPIOS:  sampled = bus_in_gpios;
            REG_SERIAL: sampled = bus_in_serial_ports;
            REG_TIMERS: sampled = bus_in_timers;
            default:    sampled = UNMAPPED_DATA;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        region_d = region_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        cyc_d    = 1'b0;
        we_g_d   = 1'b0;
        we_s_d   = 1'b0;
        we_t_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        to_ack   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d  = ST_STROBE;
                    last_d   = grant;
                    owner_d  = grant;
                    addr_d   = win_addr[BUS_ADDR_W-1:0];
                    wdata_d  = win_wdata;
                    region_d = win_region;
                    we_d     = win_we;
                    // Strobe outputs are loaded now so they are live in STROBE.
                    cyc_d    = (win_region != REG_NONE);
                    we_g_d   = win_we && (win_region == REG_GPIOS);
                    we_s_d   = win_we && (win_region == REG_SERIAL);
                    we_t_d   = win_we && (win_region == REG_TIMERS);
                end
            end
            ST_STROBE: begin
                if (WAIT_CYCLES > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_ACK;
                    to_ack  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_ACK;
                    to_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving the last STROBE/WAIT cycle: capture read data, raise ack.
        if (to_ack) begin
            if (owner_q) begin
                ack1_d = 1'b1;
                if (!we_q) rd1_d = sampled;
            end else begin
                ack0_d = 1'b1;
                if (!we_q) rd0_d = sampled;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            region_q <= REG_GPIOS;
            we_q     <= 1'b0;
            cnt_q    <= 3'd0;
            cyc_q    <= 1'b0;
            we_g_q   <= 1'b0;
            we_s_q   <= 1'b0;
            we_t_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rd0_q    <= 8'h00;
            rd1_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            region_q <= region_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            we_g_q   <= we_g_d;
            we_s_q   <= we_s_d;
            we_t_q   <= we_t_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
        end
    end

    assign m0_ack              = ack0_q;
    assign m1_ack              = ack1_q;
    assign m0_rdata            = rd0_q;
    assign m1_rdata            = rd1_q;
    assign bus_addr            = addr_q;
    assign bus_data_out        = wdata_q;
    assign bus_cyc             = cyc_q;
    assign bus_we_gpios        = we_g_q;
    assign bus_we_serial_ports = we_s_q;
    assign bus_we_timers       = we_t_q;
    assign bus_owner           = owner_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: instance 0 uses defaults, instance 1 uses
// WAIT_CYCLES=4 and UNMAPPED_DATA=8'h00. A transaction-level model predicts
// every output each cycle from request timing offsets.
module tb_periph_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]      m0_req, m1_req, m0_we, m1_we, m0_ack, m1_ack;
    logic [1:0]      bus_cyc, bus_we_g, bus_we_s, bus_we_t, bus_owner;
    logic [1:0][7:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [1:0][7:0] bus_data_out, in_g, in_s, in_t;
    logic [1:0][5:0] bus_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter dut0 (
        .wb_clk_i(clk), .rst(rst),
        .m0_req(m0_req[0]), .m1_req(m1_req[0]), .m0_we(m0_we[0]), .m1_we(m1_we[0]),
        .m0_addr(m0_addr[0]), .m1_addr(m1_addr[0]), .m0_wdata(m0_wdata[0]), .m1_wdata(m1_wdata[0]),
        .m0_ack(m0_ack[0]), .m1_ack(m1_ack[0]), .m0_rdata(m0_rdata[0]), .m1_rdata(m1_rdata[0]),
        .bus_addr(bus_addr[0]), .bus_data_out(bus_data_out[0]), .bus_cyc(bus_cyc[0]),
        .bus_we_gpios(bus_we_g[0]), .bus_we_serial_ports(bus_we_s[0]), .bus_we_timers(bus_we_t[0]),
        .bus_in_gpios(in_g[0]), .bus_in_serial_ports(in_s[0]), .bus_in_timers(in_t[0]),
        .bus_owner(bus_owner[0])
    );

    periph_bus_arbiter #(.WAIT_CYCLES(4), .UNMAPPED_DATA(8'h00)) dut1 (
        .wb_clk_i(clk), .rst(rst),
        .m0_req(m0_req[1]), .m1_req(m1_req[1]), .m0_we(m0_we[1]), .m1_we(m1_we[1]),
        .m0_addr(m0_addr[1]), .m1_addr(m1_addr[1]), .m0_wdata(m0_wdata[1]), .m1_wdata(m1_wdata[1]),
        .m0_ack(m0_ack[1]), .m1_ack(m1_ack[1]), .m0_rdata(m0_rdata[1]), .m1_rdata(m1_rdata[1]),
        .bus_addr(bus_addr[1]), .bus_data_out(bus_data_out[1]), .bus_cyc(bus_cyc[1]),
        .bus_we_gpios(bus_we_g[1]), .bus_we_serial_ports(bus_we_s[1]), .bus_we_timers(bus_we_t[1]),
        .bus_in_gpios(in_g[1]), .bus_in_serial_ports(in_s[1]), .bus_in_timers(in_t[1]),
        .bus_owner(bus_owner[1])
    );

    // ---------------- behavioural model ----------------
    function automatic int mw(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] sample(input int d, input logic [1:0] r);
        case (r)
            2'd0:    return in_g[d];
            2'd1:    return in_s[d];
            2'd2:    return in_t[d];
            default: return (d == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    logic [1:0]      busy, last, e_owner, e_cyc, e_ack0, e_ack1, mdl_we;
    logic [1:0][2:0] e_we;          // {timers, serial, gpios}
    logic [1:0][5:0] e_addr;
    logic [1:0][7:0] e_data, e_rd0, e_rd1;
    logic [1:0][1:0] mdl_region;
    int              t [2];

    // t counts cycles since the grant: strobe at t=1, ack at t=W+1.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            logic       win;
            logic [7:0] a;
            if (rst) begin
                busy[d] = 1'b0; t[d] = 0; last[d] = 1'b1; e_owner[d] = 1'b0;
                e_cyc[d] = 1'b0; e_we[d] = 3'b000; e_addr[d] = 6'h00; e_data[d] = 8'h00;
                e_ack0[d] = 1'b0; e_ack1[d] = 1'b0; e_rd0[d] = 8'h00; e_rd1[d] = 8'h00;
                mdl_we[d] = 1'b0; mdl_region[d] = 2'b00;
            end else begin
                e_cyc[d] = 1'b0; e_we[d] = 3'b000; e_ack0[d] = 1'b0; e_ack1[d] = 1'b0;
                if (!busy[d]) begin
                    if (m0_req[d] || m1_req[d]) begin
                        win = (m0_req[d] && m1_req[d]) ? !last[d] : m1_req[d];
                        a   = win ? m1_addr[d] : m0_addr[d];
                        busy[d] = 1'b1; t[d] = 1; last[d] = win; e_owner[d] = win;
                        e_addr[d] = a[5:0];
                        e_data[d] = win ? m1_wdata[d] : m0_wdata[d];
                        mdl_we[d] = win ? m1_we[d] : m0_we[d];
                        mdl_region[d] = a[7:6];
                        if (a[7:6] != 2'b11) begin
                            e_cyc[d] = 1'b1;
                            if (mdl_we[d]) e_we[d][a[7:6]] = 1'b1;
                        end
                    end
                end else if (t[d] == mw(d) + 1) begin
                    busy[d] = 1'b0;
                end else begin
                    t[d] = t[d] + 1;
                    if (t[d] == mw(d) + 1) begin
                        if (e_owner[d]) begin
                            e_ack1[d] = 1'b1;
                            if (!mdl_we[d]) e_rd1[d] = sample(d, mdl_region[d]);
                        end else begin
                            e_ack0[d] = 1'b1;
                            if (!mdl_we[d]) e_rd0[d] = sample(d, mdl_region[d]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, want %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check("owner",  d, 32'(bus_owner[d]), 32'(e_owner[d]));
            check("cyc",    d, 32'(bus_cyc[d]),   32'(e_cyc[d]));
            check("we",     d, 32'({bus_we_t[d], bus_we_s[d], bus_we_g[d]}), 32'(e_we[d]));
            check("addr",   d, 32'(bus_addr[d]),  32'(e_addr[d]));
            check("dout",   d, 32'(bus_data_out[d]), 32'(e_data[d]));
            check("ack0",   d, 32'(m0_ack[d]),    32'(e_ack0[d]));
            check("ack1",   d, 32'(m1_ack[d]),    32'(e_ack1[d]));
            check("rdata0", d, 32'(m0_rdata[d]),  32'(e_rd0[d]));
            check("rdata1", d, 32'(m1_rdata[d]),  32'(e_rd1[d]));
        end
    endtask

    // One clock: outputs are compared at the falling edge, then inputs change.
    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- directed stimulus ----------------
    int at [8];
    int who [8];
    int n;

    initial begin
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        in_g = '0; in_s = '0; in_t = '0;

        idle(2);
        check("pin_rst_owner", 0, 32'(bus_owner[0]), 32'h0);
        check("pin_rst_rdata", 1, 32'(m1_rdata[1]), 32'h00);
        rst = 1'b0;
        idle(1);

        // m0 write 0x5A to timers offset 3
        m0_addr[0] = 8'h83; m0_wdata[0] = 8'h5A; m0_we[0] = 1'b1; m0_req[0] = 1'b1;
        tick();
        check("pin_wr_cyc",  0, 32'(bus_cyc[0]), 32'h1);
        check("pin_wr_we",   0, 32'({bus_we_t[0], bus_we_s[0], bus_we_g[0]}), 32'h4);
        check("pin_wr_addr", 0, 32'(bus_addr[0]), 32'h03);
        check("pin_wr_data", 0, 32'(bus_data_out[0]), 32'h5A);
        tick();
        check("pin_wr_ack",  0, 32'(m0_ack[0]), 32'h1);
        m0_req[0] = 1'b0; m0_we[0] = 1'b0;
        idle(2);

        // m1 read of serial offset 2
        in_s[0] = 8'hC3; m1_addr[0] = 8'h42; m1_req[0] = 1'b1;
        tick();
        check("pin_rd_cyc", 0, 32'(bus_cyc[0]), 32'h1);
        check("pin_rd_we",  0, 32'({bus_we_t[0], bus_we_s[0], bus_we_g[0]}), 32'h0);
        tick();
        check("pin_rd_ack",   0, 32'(m1_ack[0]), 32'h1);
        check("pin_rd_data",  0, 32'(m1_rdata[0]), 32'hC3);
        check("pin_rd_other", 0, 32'(m0_ack[0]), 32'h0);
        m1_req[0] = 1'b0;
        idle(2);

        // request dropped right after grant still completes
        m0_addr[0] = 8'h85; in_t[0] = 8'h3C; m0_req[0] = 1'b1;
        tick();
        m0_req[0] = 1'b0;
        tick();
        check("pin_drop_ack",  0, 32'(m0_ack[0]), 32'h1);
        check("pin_drop_data", 0, 32'(m0_rdata[0]), 32'h3C);
        idle(2);
        check("pin_drop_noack", 0, 32'(m0_ack[0]), 32'h0);

        // both requesting continuously from reset: alternate 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0; tick();
        m0_addr[0] = 8'h01; m1_addr[0] = 8'h82; in_g[0] = 8'hA1; in_t[0] = 8'hB2;
        m0_req[0] = 1'b1; m1_req[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if ((m0_ack[0] || m1_ack[0]) && n < 8) begin
                at[n] = c; who[n] = int'(m1_ack[0]); n++;
            end
        end
        m0_req[0] = 1'b0; m1_req[0] = 1'b0;
        check("pin_rr_count", 0, 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("pin_rr_owner", 0, 32'(who[k]), 32'(k % 2));
            check("pin_rr_time",  0, 32'(at[k]),  32'(2 + 3 * k));
        end
        idle(2);

        // unmapped read on both instances
        m0_addr[0] = 8'hC0; m0_addr[1] = 8'hC0; m0_req[0] = 1'b1; m0_req[1] = 1'b1;
        tick();
        check("pin_um_cyc", 0, 32'(bus_cyc[0]), 32'h0);
        check("pin_um_cyc", 1, 32'(bus_cyc[1]), 32'h0);
        tick();
        check("pin_um_ack",  0, 32'(m0_ack[0]), 32'h1);
        check("pin_um_data", 0, 32'(m0_rdata[0]), 32'hFF);
        m0_req[0] = 1'b0;
        idle(3);
        check("pin_um_ack",  1, 32'(m0_ack[1]), 32'h1);
        check("pin_um_data", 1, 32'(m0_rdata[1]), 32'h00);
        m0_req[1] = 1'b0;
        idle(2);

        // WAIT_CYCLES=4 gpios read: data sampled in cycle 4, ack in cycle 5
        in_g[1] = 8'h11; m0_addr[1] = 8'h05; m0_req[1] = 1'b1;
        tick();
        check("pin_w4_cyc1", 1, 32'(bus_cyc[1]), 32'h1);
        tick();
        check("pin_w4_cyc2", 1, 32'(bus_cyc[1]), 32'h0);
        tick();
        tick();
        check("pin_w4_addr4", 1, 32'(bus_addr[1]), 32'h05);
        check("pin_w4_noack", 1, 32'(m0_ack[1]), 32'h0);
        in_g[1] = 8'h77;
        tick();
        check("pin_w4_ack",  1, 32'(m0_ack[1]), 32'h1);
        check("pin_w4_data", 1, 32'(m0_rdata[1]), 32'h77);
        m0_req[1] = 1'b0;
        idle(2);

        // reset during WAIT drops the access; a fresh m1 write then completes
        m0_addr[1] = 8'h82; m0_req[1] = 1'b1;
        idle(2);
        rst = 1'b1; m0_req[1] = 1'b0;
        tick();
        check("pin_rw_ack",   1, 32'(m0_ack[1]), 32'h0);
        check("pin_rw_rdata", 1, 32'(m0_rdata[1]), 32'h00);
        check("pin_rw_addr",  1, 32'(bus_addr[1]), 32'h00);
        rst = 1'b0;
        idle(3);
        check("pin_rw_lost", 1, 32'(m0_ack[1]), 32'h0);
        m1_addr[1] = 8'h47; m1_wdata[1] = 8'hE4; m1_we[1] = 1'b1; m1_req[1] = 1'b1;
        tick();
        check("pin_nw_we",    1, 32'(bus_we_s[1]), 32'h1);
        check("pin_nw_owner", 1, 32'(bus_owner[1]), 32'h1);
        check("pin_nw_addr",  1, 32'(bus_addr[1]), 32'h07);
        idle(3);
        tick();
        check("pin_nw_ack",   1, 32'(m1_ack[1]), 32'h1);
        check("pin_nw_rdata", 1, 32'(m1_rdata[1]), 32'h00);
        m1_req[1] = 1'b0; m1_we[1] = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
